// File: rtl/prng_byte_unpacker.sv
// -----------------------------------------------------------------------------
// prng_byte_unpacker
//
// Purpose:
//   Byte-granular unpacker placed between the ChaCha20 PRNG core and SamplerZ.
//   It accepts 512-bit keystream blocks into a 128-byte circular buffer made
//   of two 64-byte halves. It serves requests of 1..MAX_REQ bytes in stream
//   order, and a request may straddle either half boundary.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush_i      discard all buffered bytes (priority over fill and serve)
//   blk_valid_i  upstream block available
//   blk_data_i   upstream block, byte k = blk_data_i[8k+:8]
//   blk_ready_o  block accepted when blk_valid_i & blk_ready_o
//   req_valid_i  downstream byte request
//   req_len_i    requested length in bytes, legal 1..MAX_REQ
//   req_ready_o  request accepted when req_valid_i & req_ready_o
//   rsp_valid_o  one-cycle response strobe, the cycle after acceptance
//   rsp_data_o   response bytes, little-endian, zero above 8*len
//   level_o      registered count of buffered bytes (0..128)
//   err_o        sticky illegal-length flag, cleared only by rst
//   byte_cnt_o   (PRNG_UNPACK_STATS_EN only) total bytes delivered, mod 2^32
//
// Configuration:
//   PRNG_UNPACK_STATS_EN  when defined, adds byte_cnt_o and its counter.
// -----------------------------------------------------------------------------
module prng_byte_unpacker #(
  parameter int BLK_BYTES = 64,
  parameter int MAX_REQ   = 9,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     blk_valid_i,
  input  logic [8*BLK_BYTES-1:0]   blk_data_i,
  output logic                     blk_ready_o,
  input  logic                     req_valid_i,
  input  logic [3:0]               req_len_i,
  output logic                     req_ready_o,
  output logic                     rsp_valid_o,
  output logic [8*MAX_REQ-1:0]     rsp_data_o,
  output logic [CNT_W-1:0]         level_o,
  output logic                     err_o
`ifdef PRNG_UNPACK_STATS_EN
  ,
  output logic [31:0]              byte_cnt_o
`endif
);

  localparam int BUF_BYTES = 2 * BLK_BYTES;
  localparam int AW        = $clog2(BUF_BYTES);
  localparam int HW        = AW - 1;
  localparam logic [CNT_W-1:0] BLK_LVL = CNT_W'(BLK_BYTES);
  localparam logic [3:0]       MAX_LEN = 4'(MAX_REQ);

  logic [7:0]             buf_r [BUF_BYTES];
  logic                   wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]       level_r;
  logic                   rsp_valid_r;
  logic [8*MAX_REQ-1:0]   rsp_data_r;
  logic                   err_r;

  logic                   len_ok_s;
  logic                   fill_s;
  logic                   serve_s;
  logic [CNT_W-1:0]       level_nxt_s;
  logic [8*MAX_REQ-1:0]   rsp_nxt_s;

  // Handshakes and next fill level; readiness looks only at the pre-update level.
  always_comb begin
    len_ok_s    = (req_len_i != 4'd0) && (req_len_i <= MAX_LEN);
    blk_ready_o = (level_r <= BLK_LVL) && !flush_i;
    req_ready_o = len_ok_s && (level_r >= CNT_W'(req_len_i)) && !flush_i;
    fill_s      = blk_valid_i && blk_ready_o;
    serve_s     = req_valid_i && req_ready_o;
    level_nxt_s = level_r
                + (fill_s  ? BLK_LVL            : {CNT_W{1'b0}})
                - (serve_s ? CNT_W'(req_len_i)  : {CNT_W{1'b0}});
  end

  // Gather the requested bytes in stream order; the index wraps naturally mod 128.
  always_comb begin
    rsp_nxt_s = {(8*MAX_REQ){1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      if (4'(i) < req_len_i) begin
        rsp_nxt_s[8*i +: 8] = buf_r[rd_ptr_r + AW'(i)];
      end else begin
        rsp_nxt_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Buffer storage: an accepted block always lands on a half boundary.
  // A block is accepted only while level <= 64, so the target half holds no unread bytes.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      for (int k = 0; k < BLK_BYTES; k++) begin
        buf_r[{wr_ptr_r, HW'(k)}] <= blk_data_i[8*k +: 8];
      end
    end
  end

  // Pointers, level and response registers; flush overrides fill and serve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {CNT_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {(8*MAX_REQ){1'b0}};
    end else if (flush_i) begin
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {CNT_W{1'b0}};
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= serve_s;
      level_r     <= level_nxt_s;
      if (fill_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (serve_s) begin
        rsp_data_r <= rsp_nxt_s;
        rd_ptr_r   <= rd_ptr_r + AW'(req_len_i);
      end
    end
  end

  // Sticky error on any presented request with an illegal length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (req_valid_i && !len_ok_s) begin
      err_r <= 1'b1;
    end
  end

  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign level_o     = level_r;
  assign err_o       = err_r;

`ifdef PRNG_UNPACK_STATS_EN
  logic [31:0] byte_cnt_r;

  // Delivered-byte counter, cleared by reset and flush, wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_r <= 32'd0;
    end else if (flush_i) begin
      byte_cnt_r <= 32'd0;
    end else if (serve_s) begin
      byte_cnt_r <= byte_cnt_r + 32'(req_len_i);
    end
  end

  assign byte_cnt_o = byte_cnt_r;
`endif

endmodule

// File: tb/tb_prng_byte_unpacker.sv
// -----------------------------------------------------------------------------
// tb_prng_byte_unpacker
//
// Directed self-checking bench for prng_byte_unpacker. Keystream blocks carry
// consecutive byte values, so stream position p holds byte value p mod 256.
// Expected response bytes come from a running next-byte model and from
// hand-written constants.
// -----------------------------------------------------------------------------
module tb_prng_byte_unpacker;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic         blk_valid_i;
  logic [511:0] blk_data_i;
  logic         blk_ready_o;
  logic         req_valid_i;
  logic [3:0]   req_len_i;
  logic         req_ready_o;
  logic         rsp_valid_o;
  logic [71:0]  rsp_data_o;
  logic [7:0]   level_o;
  logic         err_o;
`ifdef PRNG_UNPACK_STATS_EN
  logic [31:0]  byte_cnt_o;
`endif

  int         n_checks;
  int         n_errors;
  logic [7:0] next_byte;
  int         exp_level;

  prng_byte_unpacker dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .blk_valid_i (blk_valid_i),
    .blk_data_i  (blk_data_i),
    .blk_ready_o (blk_ready_o),
    .req_valid_i (req_valid_i),
    .req_len_i   (req_len_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .level_o     (level_o),
    .err_o       (err_o)
`ifdef PRNG_UNPACK_STATS_EN
    ,
    .byte_cnt_o  (byte_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] stream_bytes(input logic [7:0] start, input int len);
    logic [71:0] d;
    logic [7:0]  b;
    d = 72'h0;
    b = start;
    for (int i = 0; i < len; i++) begin
      d[8*i +: 8] = b;
      b = b + 8'd1;
    end
    return d;
  endfunction

  task automatic drive(input logic fl, input logic bv, input logic [7:0] base,
                       input logic rv, input logic [3:0] len);
    flush_i     = fl;
    blk_valid_i = bv;
    for (int k = 0; k < 64; k++) blk_data_i[8*k +: 8] = base + 8'(k);
    req_valid_i = rv;
    req_len_i   = len;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic put_block(input logic [7:0] base, input logic ready_after);
    @(negedge clk);
    drive(1'b0, 1'b1, base, 1'b0, 4'd0);
    #1;
    chk("blk_ready_before", {71'h0, blk_ready_o}, 72'h1);
    @(posedge clk);
    #1;
    exp_level = exp_level + 64;
    chk("level_after_fill", {64'h0, level_o}, 72'(exp_level));
    chk("blk_ready_after", {71'h0, blk_ready_o}, {71'h0, ready_after});
  endtask

  task automatic serve(input int len);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 4'(len));
    #1;
    chk("req_ready", {71'h0, req_ready_o}, 72'h1);
    @(posedge clk);
    #1;
    exp_level = exp_level - len;
    chk("rsp_valid", {71'h0, rsp_valid_o}, 72'h1);
    chk("rsp_data", rsp_data_o, stream_bytes(next_byte, len));
    chk("level_after_serve", {64'h0, level_o}, 72'(exp_level));
    next_byte = next_byte + 8'(len);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    next_byte = 8'h00;
    exp_level = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    #2;
    chk("rst_blk_ready", {71'h0, blk_ready_o}, 72'h1);
    chk("rst_req_ready", {71'h0, req_ready_o}, 72'h0);
    chk("rst_rsp_valid", {71'h0, rsp_valid_o}, 72'h0);
    chk("rst_rsp_data", rsp_data_o, 72'h0);
    chk("rst_level", {64'h0, level_o}, 72'h0);
    chk("rst_err", {71'h0, err_o}, 72'h0);
    @(negedge clk);
    rst = 1'b0;

    // T1/T2: first block, then a 9-byte request at level 64
    put_block(8'h00, 1'b1);
    serve(9);
    chk("t2_const", rsp_data_o, 72'h08_0706_0504_0302_0100);
    chk("t2_level", {64'h0, level_o}, 72'd55);

    // T3: consume to rd_ptr 60 (back-to-back requests), then straddle 63->64
    for (int i = 0; i < 5; i++) serve(9);
    serve(6);
    chk("t3_level4", {64'h0, level_o}, 72'd4);
    put_block(8'h40, 1'b0);
    serve(9);
    chk("t3_straddle_half", rsp_data_o, 72'h44_4342_4140_3F3E_3D3C);
    idle_cycle();
    chk("rsp_one_cycle", {71'h0, rsp_valid_o}, 72'h0);

    // T3: walk rd_ptr to 124 and straddle 127->0
    put_block(8'h80, 1'b0);
    for (int i = 0; i < 6; i++) serve(9);
    serve(1);
    serve(9);
    chk("t3_straddle_wrap", rsp_data_o, 72'h84_8382_8180_7F7E_7D7C);

    // T4: drain to level 5, stall a 9-byte request, then fill + serve together
    for (int i = 0; i < 6; i++) serve(9);
    chk("t4_level5", {64'h0, level_o}, 72'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 4'd9);
    #1;
    chk("t4_stall_ready", {71'h0, req_ready_o}, 72'h0);
    @(posedge clk);
    #1;
    chk("t4_stall_rsp", {71'h0, rsp_valid_o}, 72'h0);
    chk("t4_stall_level", {64'h0, level_o}, 72'd5);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hC0, 1'b1, 4'd1);
    #1;
    chk("t4_both_blk_ready", {71'h0, blk_ready_o}, 72'h1);
    chk("t4_both_req_ready", {71'h0, req_ready_o}, 72'h1);
    @(posedge clk);
    #1;
    exp_level = exp_level + 64 - 1;
    chk("t4_both_rsp_valid", {71'h0, rsp_valid_o}, 72'h1);
    chk("t4_both_rsp_data", rsp_data_o, 72'hBB);
    chk("t4_both_level", {64'h0, level_o}, 72'd68);
    next_byte = next_byte + 8'd1;
    serve(9);
    put_block(8'h00, 1'b0);

    // T5: illegal lengths, then flush with block and request present
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    #1;
    chk("t5_len0_ready", {71'h0, req_ready_o}, 72'h0);
    @(posedge clk);
    #1;
    chk("t5_err", {71'h0, err_o}, 72'h1);
    chk("t5_level_hold", {64'h0, level_o}, 72'd123);
    chk("t5_len0_rsp", {71'h0, rsp_valid_o}, 72'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 4'd10);
    #1;
    chk("t5_len10_ready", {71'h0, req_ready_o}, 72'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h55, 1'b1, 4'd1);
    #1;
    chk("t5_flush_blk_ready", {71'h0, blk_ready_o}, 72'h0);
    chk("t5_flush_req_ready", {71'h0, req_ready_o}, 72'h0);
    @(posedge clk);
    #1;
    chk("t5_flush_level", {64'h0, level_o}, 72'h0);
    chk("t5_flush_rsp", {71'h0, rsp_valid_o}, 72'h0);
    idle_cycle();
    chk("t5_dropped_level", {64'h0, level_o}, 72'h0);
    chk("t5_err_sticky", {71'h0, err_o}, 72'h1);

    // T1 second half: two blocks fill to 128; pointers restarted at 0
    exp_level = 0;
    put_block(8'hA0, 1'b1);
    put_block(8'hE0, 1'b0);
    next_byte = 8'hA0;
    serve(3);
    chk("flush_ptrs", rsp_data_o, 72'hA2A1A0);

    // Reset mid-operation takes effect immediately
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_level", {64'h0, level_o}, 72'h0);
    chk("midrst_err", {71'h0, err_o}, 72'h0);
    chk("midrst_blk_ready", {71'h0, blk_ready_o}, 72'h1);
    chk("midrst_rsp_data", rsp_data_o, 72'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_level = 0;
    next_byte = 8'h00;

`ifdef PRNG_UNPACK_STATS_EN
    // T6: delivered-byte counter
    put_block(8'h00, 1'b1);
    serve(9);
    serve(1);
    serve(9);
    chk("t6_byte_cnt", {40'h0, byte_cnt_o}, 72'd19);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk("t6_byte_cnt_flush", {40'h0, byte_cnt_o}, 72'd0);
    idle_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
